result_reporter: RTL and testbench

RESULT_REPORTER -- requirements
Module: result_reporter

---
 rtl/atr_pkg.sv | 15 +
 rtl/nibble_to_ascii.sv | 7 +
 rtl/result_reporter.sv | 110 +++++++++++
 tb/tb_result_reporter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/atr_pkg.sv
// atr_pkg: shared state encoding, default UART register map and ASCII control constants
// for result_reporter.
package atr_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t POLL_REQ = 3'd1;
    localparam state_t POLL_CHK = 3'd2;
    localparam state_t WRITE    = 3'd3;
    localparam state_t NEXT     = 3'd4;
    localparam state_t FIN      = 3'd5;
    localparam logic [7:0] DEF_STATUS_ADDR = 8'd1;
    localparam logic [7:0] DEF_DATA_ADDR   = 8'd2;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: maps a 4-bit value to its uppercase ASCII hex digit.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    assign ascii = (nibble < 4'd10) ? 8'h30 + {4'd0, nibble} : 8'h37 + {4'd0, nibble};
endmodule

// File: rtl/result_reporter.sv
// result_reporter: writes a 16-bit result to a polled UART, one byte per ready poll.
// REPORT_ASCII_EN selects 4 hex digits + CR/LF; otherwise 2 raw bytes, low byte first.
module result_reporter
    import atr_pkg::*;
#(
    parameter logic [7:0]  STATUS_ADDR  = DEF_STATUS_ADDR,
    parameter logic [7:0]  DATA_ADDR    = DEF_DATA_ADDR,
    parameter int unsigned TX_READY_BIT = 1,
    parameter logic [31:0] POLL_TIMEOUT = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  uart_address,
    output logic [7:0]  uart_din,
    output logic        uart_w_en,
    output logic        uart_r_en,
    input  logic [7:0]  uart_dout
);
`ifdef REPORT_ASCII_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd1;
`endif
    state_t      state;
    logic [15:0] held;
    logic [2:0]  idx;
    logic [31:0] poll_cnt;
    logic [7:0]  cur_byte;
`ifdef REPORT_ASCII_EN
    logic [3:0] nib;
    logic [7:0] asc;
    assign nib = (idx == 3'd0) ? held[15:12] :
                 (idx == 3'd1) ? held[11:8]  :
                 (idx == 3'd2) ? held[7:4]   : held[3:0];
    nibble_to_ascii u_n2a (.nibble(nib), .ascii(asc));
    assign cur_byte = (idx < 3'd4) ? asc : (idx == 3'd4) ? ASCII_CR : ASCII_LF;
`else
    assign cur_byte = idx[0] ? held[15:8] : held[7:0];
`endif
    // Outputs are registered from the next state, so each state's drive is visible while in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            held         <= '0;
            idx          <= '0;
            poll_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            uart_address <= '0;
            uart_din     <= '0;
            uart_w_en    <= 1'b0;
            uart_r_en    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    held         <= result;
                    idx          <= '0;
                    poll_cnt     <= '0;
                    error        <= 1'b0;
                    busy         <= 1'b1;
                    uart_r_en    <= 1'b1;
                    uart_address <= STATUS_ADDR;
                    state        <= POLL_REQ;
                end
                POLL_REQ: state <= POLL_CHK;
                POLL_CHK: if (uart_dout[TX_READY_BIT]) begin
                    uart_r_en    <= 1'b0;
                    uart_w_en    <= 1'b1;
                    uart_address <= DATA_ADDR;
                    uart_din     <= cur_byte;
                    state        <= WRITE;
                end else begin
                    poll_cnt <= poll_cnt + 32'd1;
                    if (poll_cnt + 32'd1 == POLL_TIMEOUT) begin
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        uart_r_en <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    uart_w_en <= 1'b0;
                    state     <= NEXT;
                end
                NEXT: begin
                    idx <= idx + 3'd1;
                    if (idx == LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        poll_cnt     <= '0;
                        uart_r_en    <= 1'b1;
                        uart_address <= STATUS_ADDR;
                        state        <= POLL_REQ;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_reporter.sv
// tb_result_reporter: directed checks of result_reporter (default and REPORT_ASCII_EN builds),
// plus a POLL_TIMEOUT=16 instance for the timeout path.
module tb_result_reporter;
`ifdef REPORT_ASCII_EN
    localparam int N = 6;
    logic [7:0] exp_a [N] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    logic [7:0] exp_b [N] = '{8'h41, 8'h30, 8'h35, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] exp_c [N] = '{8'h30, 8'h30, 8'h43, 8'h33, 8'h0D, 8'h0A};
`else
    localparam int N = 2;
    logic [7:0] exp_a [N] = '{8'h34, 8'h12};
    logic [7:0] exp_b [N] = '{8'h5F, 8'hA0};
    logic [7:0] exp_c [N] = '{8'hC3, 8'h00};
`endif
    logic clk = 0, rst_n = 0;
    logic start = 0, ready = 1, start_t = 0, ready_t = 0;
    logic [15:0] result = '0;
    logic busy, done, error, w_en, r_en, busy_t, done_t, error_t, w_en_t, r_en_t;
    logic [7:0] addr, din, dout, addr_t, din_t, dout_t;
    logic [7:0] wr_data[$], wr_addr[$];
    int checks = 0, errors = 0, done_cnt = 0, done_t_cnt = 0, cyc;

    assign dout   = ready   ? 8'h02 : 8'h00;
    assign dout_t = ready_t ? 8'h02 : 8'h00;

    result_reporter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .result(result),
        .busy(busy), .done(done), .error(error),
        .uart_address(addr), .uart_din(din), .uart_w_en(w_en), .uart_r_en(r_en),
        .uart_dout(dout)
    );
    result_reporter #(.POLL_TIMEOUT(32'd16)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .result(result),
        .busy(busy_t), .done(done_t), .error(error_t),
        .uart_address(addr_t), .uart_din(din_t), .uart_w_en(w_en_t), .uart_r_en(r_en_t),
        .uart_dout(dout_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input logic [7:0] e [N]);
        chk({tag, "_count"}, wr_data.size(), N);
        for (int i = 0; i < N && i < wr_data.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, wr_data[i]}, {24'd0, e[i]});
            chk($sformatf("%s_addr%0d", tag, i), {24'd0, wr_addr[i]}, 32'd2);
        end
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_addr.delete();
        done_cnt = 0;
        done_t_cnt = 0;
    endtask

    task automatic wait_done(input string tag);
        while (!done && cyc < 500) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    always @(negedge clk) begin
        if (w_en) begin
            wr_data.push_back(din);
            wr_addr.push_back(addr);
        end
        if (done) done_cnt++;
        if (done_t) done_t_cnt++;
        if (rst_n) chk("w_r_overlap", {30'd0, w_en & r_en, w_en_t & r_en_t}, 0);
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wen_ren", {w_en, r_en}, 0);
        chk("rst_addr_din", {addr, din}, 0);
        rst_n = 1;
        tick();
        clear_log();

        // Raw/ASCII report of 0x1234 with ready always high: exact latency 1 + 4N.
        result = 16'h1234; start = 1; tick(); start = 0; cyc = 1;
        chk("a_busy", busy, 1);
        chk("a_poll_drive", {r_en, w_en, addr}, {2'b10, 8'd1});
        wait_done("a");
        chk("a_latency", cyc, 1 + 4 * N);
        chk("a_busy_at_done", busy, 0);
        tick();
        chk("a_done_pulse", done, 0);
        check_writes("a", exp_a);
        chk("a_done_count", done_cnt, 1);

        // 0xA05F with a second start (0xFFFF) arriving mid-report.
        clear_log();
        result = 16'hA05F; start = 1; tick(); start = 0; cyc = 1;
        tick(); tick(); cyc += 2;
        result = 16'hFFFF; start = 1; tick(); start = 0; result = 16'h0000; cyc++;
        wait_done("b");
        tick();
        check_writes("b", exp_b);
        chk("b_done_count", done_cnt, 1);

        // Ready stalls for 50 cycles after the first byte.
        clear_log();
        result = 16'h00C3; ready = 1; start = 1; tick(); start = 0; cyc = 1;
        while (wr_data.size() < 1 && cyc < 100) begin tick(); cyc++; end
        chk("c_first_write", wr_data.size(), 1);
        ready = 0;
        repeat (50) tick();
        chk("c_stall_no_write", wr_data.size(), 1);
        chk("c_stall_busy", busy, 1);
        ready = 1; cyc = 0;
        wait_done("c");
        tick();
        check_writes("c", exp_c);
        chk("c_done_count", done_cnt, 1);

        // Timeout instance: error after 16 not-ready polls, then cleared by next start.
        clear_log();
        ready_t = 0; start_t = 1; tick(); start_t = 0; cyc = 1;
        while (cyc < 17) begin tick(); cyc++; end
        chk("t_error_before", error_t, 0);
        chk("t_busy_before", busy_t, 1);
        tick();
        chk("t_error_set", error_t, 1);
        chk("t_busy_clear", busy_t, 0);
        chk("t_ren_clear", r_en_t, 0);
        repeat (10) tick();
        chk("t_error_sticky", error_t, 1);
        chk("t_no_done", done_t_cnt, 0);
        ready_t = 1; start_t = 1; tick(); start_t = 0; cyc = 1;
        chk("t_error_cleared", error_t, 0);
        chk("t_busy_restart", busy_t, 1);
        while (!done_t && cyc < 200) begin tick(); cyc++; end
        chk("t_done_after_restart", done_t, 1);
        tick();
        chk("t_done_count", done_t_cnt, 1);

        // Reset while the first byte is being written.
        clear_log();
        result = 16'h1234; start = 1; tick(); start = 0; cyc = 1;
        while (!w_en && cyc < 50) begin tick(); cyc++; end
        chk("r_in_write", w_en, 1);
        rst_n = 0;
        #1;
        chk("r_async_wen", w_en, 0);
        chk("r_async_busy", busy, 0);
        chk("r_async_ren", r_en, 0);
        chk("r_async_addr_din", {addr, din}, 0);
        tick(); tick();
        rst_n = 1;
        repeat (40) tick();
        chk("r_no_writes", wr_data.size(), 0);
        chk("r_no_done", done_cnt, 0);
        chk("r_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
